// File: rtl/uart_pkg.sv
// uart_pkg: shared state encoding and ASCII constants for the UART word sender
package uart_pkg;
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SEND = 2'd1;
    localparam logic [1:0] WAIT = 2'd2;
    typedef enum logic [1:0] {
        ST_IDLE = IDLE,
        ST_SEND = SEND,
        ST_WAIT = WAIT
    } state_t;
    localparam logic [7:0] ASCII_ZERO = 8'h30;
    localparam logic [7:0] ASCII_A    = 8'h41;
endpackage

// File: rtl/hex_nibble_to_ascii.sv
// hex_nibble_to_ascii: maps a 4-bit nibble to its uppercase ASCII hex character
module hex_nibble_to_ascii
    import uart_pkg::*;
(
    input  logic [3:0] i_nib,
    output logic [7:0] o_char
);
    assign o_char = (i_nib < 4'd10) ? ASCII_ZERO + {4'd0, i_nib}
                                    : ASCII_A + {4'd0, i_nib} - 8'd10;
endmodule

// File: rtl/uart_word_sender.sv
// uart_word_sender: splits a wide word into bytes (or hex characters with UART_HEX_ASCII_EN) for a UART transmitter
module uart_word_sender
    import uart_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] word_din,
    input  logic             word_valid,
    output logic             word_ready,
    output logic             tx_start,
    output logic [7:0]       tx_din,
    input  logic             tx_done_tick,
    output logic             busy,
    output logic             done_tick
);
    localparam int NBYTES = WIDTH / 8;
`ifdef UART_HEX_ASCII_EN
    localparam int NCHARS = 2 * NBYTES;
`else
    localparam int NCHARS = NBYTES;
`endif
    localparam int CW = $clog2(NCHARS + 1);
    localparam logic [CW-1:0] LAST = CW'(NCHARS - 1);

    state_t           r_state, w_next;
    logic [WIDTH-1:0] r_shift, w_shift_nx;
    logic [CW-1:0]    r_cnt;
    logic             r_done;
    logic             w_last;
    logic [7:0]       w_char;

    assign w_last = (r_cnt == LAST);

`ifdef UART_HEX_ASCII_EN
    logic [3:0] w_nib;
    // LSB-first keeps the byte in place for its high/low characters, then drops it
    assign w_nib      = MSB_FIRST ? r_shift[WIDTH-1 -: 4] : (r_cnt[0] ? r_shift[3:0] : r_shift[7:4]);
    assign w_shift_nx = MSB_FIRST ? r_shift << 4 : (r_cnt[0] ? r_shift >> 8 : r_shift);
    hex_nibble_to_ascii u_hex (
        .i_nib  (w_nib),
        .o_char (w_char)
    );
`else
    assign w_char     = MSB_FIRST ? r_shift[WIDTH-1 -: 8] : r_shift[7:0];
    assign w_shift_nx = MSB_FIRST ? r_shift << 8 : r_shift >> 8;
`endif

    assign word_ready = (r_state == ST_IDLE);
    assign busy       = (r_state != ST_IDLE);
    assign tx_start   = (r_state == ST_SEND);
    assign tx_din     = busy ? w_char : 8'h00;
    assign done_tick  = r_done;

    // next-state decode
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE: w_next = word_valid ? ST_SEND : ST_IDLE;
            ST_SEND: w_next = ST_WAIT;
            ST_WAIT: w_next = tx_done_tick ? (w_last ? ST_IDLE : ST_SEND) : ST_WAIT;
            default: w_next = ST_IDLE;
        endcase
    end

    // state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= ST_IDLE;
        else          r_state <= w_next;
    end

    // word capture, per-transfer shift/count and completion pulse
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_shift <= '0;
            r_cnt   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= (r_state == ST_WAIT) && tx_done_tick && w_last;
            if (r_state == ST_IDLE && word_valid) begin
                r_shift <= word_din;
                r_cnt   <= '0;
            end else if (r_state == ST_WAIT && tx_done_tick && !w_last) begin
                r_shift <= w_shift_nx;
                r_cnt   <= r_cnt + CW'(1);
            end
        end
    end
endmodule

// File: tb/tb_uart_word_sender.sv
// tb_uart_word_sender: randomized and directed checks of uart_word_sender against a character-list model (honours UART_HEX_ASCII_EN)
module tb_uart_word_sender;
    typedef logic [7:0] bq_t[$];

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] word_din = '0;
    logic        word_valid = 1'b0;
    logic        tx_done = 1'b0;
    logic        a_ready, a_start, a_busy, a_done;
    logic        b_ready, b_start, b_busy, b_done;
    logic [7:0]  a_din, b_din;
    logic [7:0]  c_word = '0;
    logic        c_valid = 1'b0;
    logic        c_txdone = 1'b0;
    logic        c_ready, c_start, c_busy, c_done;
    logic [7:0]  c_din;
    int          n_assert = 0;
    int          n_fail = 0;

    uart_word_sender #(.WIDTH(32), .MSB_FIRST(1'b1)) u_a (
        .clk(clk), .reset_n(reset_n), .word_din(word_din), .word_valid(word_valid),
        .word_ready(a_ready), .tx_start(a_start), .tx_din(a_din), .tx_done_tick(tx_done),
        .busy(a_busy), .done_tick(a_done)
    );
    uart_word_sender #(.WIDTH(32), .MSB_FIRST(1'b0)) u_b (
        .clk(clk), .reset_n(reset_n), .word_din(word_din), .word_valid(word_valid),
        .word_ready(b_ready), .tx_start(b_start), .tx_din(b_din), .tx_done_tick(tx_done),
        .busy(b_busy), .done_tick(b_done)
    );
    uart_word_sender #(.WIDTH(8), .MSB_FIRST(1'b1)) u_c (
        .clk(clk), .reset_n(reset_n), .word_din(c_word), .word_valid(c_valid),
        .word_ready(c_ready), .tx_start(c_start), .tx_din(c_din), .tx_done_tick(c_txdone),
        .busy(c_busy), .done_tick(c_done)
    );

    // free-running clock
    always #5 clk = ~clk;

    function automatic logic [7:0] asc(input logic [3:0] n);
        return (n < 4'd10) ? 8'h30 + 8'(n) : 8'h41 + 8'(n) - 8'd10;
    endfunction

    function automatic bq_t model(input logic [31:0] w, input bit msb, input int nb);
        bq_t q;
        for (int k = 0; k < nb; k++) begin
            int bi;
            logic [7:0] b;
            bi = msb ? nb - 1 - k : k;
            b = w[bi*8 +: 8];
`ifdef UART_HEX_ASCII_EN
            q.push_back(asc(b[7:4]));
            q.push_back(asc(b[3:0]));
`else
            q.push_back(b);
`endif
        end
        return q;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n, input bit spur);
        word_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            tx_done = spur ? 1'($urandom_range(0, 1)) : 1'b0;
            @(negedge clk);
            check("idle_start", {30'd0, a_start, b_start}, 0);
            check("idle_busy", {30'd0, a_busy, b_busy}, 0);
            check("idle_ready", {30'd0, a_ready, b_ready}, 3);
            check("idle_done", {30'd0, a_done, b_done}, 0);
        end
        tx_done = 1'b0;
    endtask

    task automatic xfer(input logic [31:0] w, input int lat, input bit keep, input logic [31:0] nxt);
        bq_t qa, qb;
        qa = model(w, 1'b1, 4);
        qb = model(w, 1'b0, 4);
        tx_done = 1'b0;
        word_din = w;
        word_valid = 1'b1;
        @(negedge clk);
        foreach (qa[i]) begin
            check("send_start", {30'd0, a_start, b_start}, 3);
            check("send_din_a", {24'd0, a_din}, {24'd0, qa[i]});
            check("send_din_b", {24'd0, b_din}, {24'd0, qb[i]});
            check("send_ready", {30'd0, a_ready, b_ready}, 0);
            check("send_busy", {30'd0, a_busy, b_busy}, 3);
            check("send_done", {30'd0, a_done, b_done}, 0);
            word_din = keep ? nxt : $urandom;
            word_valid = keep ? 1'b1 : 1'($urandom_range(0, 1));
            tx_done = 1'($urandom_range(0, 1));
            for (int j = 0; j < lat; j++) begin
                @(negedge clk);
                tx_done = 1'b0;
                check("wait_start", {30'd0, a_start, b_start}, 0);
                check("wait_din_a", {24'd0, a_din}, {24'd0, qa[i]});
                check("wait_din_b", {24'd0, b_din}, {24'd0, qb[i]});
                check("wait_done", {30'd0, a_done, b_done}, 0);
            end
            tx_done = 1'b1;
            @(negedge clk);
            tx_done = 1'b0;
        end
        check("fin_done", {30'd0, a_done, b_done}, 3);
        check("fin_ready", {30'd0, a_ready, b_ready}, 3);
        check("fin_busy", {30'd0, a_busy, b_busy}, 0);
        check("fin_start", {30'd0, a_start, b_start}, 0);
        word_valid = keep;
        word_din = nxt;
    endtask

    initial begin
        logic [31:0] words[9];
        bq_t qr;
        repeat (3) @(negedge clk);
        check("rst_start", {30'd0, a_start, b_start}, 0);
        check("rst_din", {16'd0, a_din, b_din}, 0);
        check("rst_busy", {30'd0, a_busy, b_busy}, 0);
        check("rst_done", {30'd0, a_done, b_done}, 0);
        reset_n = 1'b1;
        @(negedge clk);
        check("rel_ready", {29'd0, a_ready, b_ready, c_ready}, 7);
        xfer(32'hA1B2C3D4, 20, 1'b0, 32'h0);
        idle(2, 1'b0);
        xfer(32'h11223344, 20, 1'b1, 32'h55667788);
        xfer(32'h55667788, 20, 1'b0, 32'h0);
        idle(3, 1'b0);
        idle(20, 1'b1);
        xfer($urandom, 1000, 1'b0, 32'h0);
        idle(10, 1'b1);
        qr = model(32'hCAFEBABE, 1'b1, 4);
        word_din = 32'hCAFEBABE;
        word_valid = 1'b1;
        @(negedge clk);
        check("rt_start0", {31'd0, a_start}, 1);
        word_valid = 1'b0;
        repeat (5) @(negedge clk);
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
        check("rt_start1", {31'd0, a_start}, 1);
        check("rt_din1", {24'd0, a_din}, {24'd0, qr[1]});
        repeat (3) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("rt_start", {30'd0, a_start, b_start}, 0);
        check("rt_din", {16'd0, a_din, b_din}, 0);
        check("rt_busy", {30'd0, a_busy, b_busy}, 0);
        check("rt_done", {30'd0, a_done, b_done}, 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("rt_ready", {30'd0, a_ready, b_ready}, 3);
        xfer(32'h0000FFFF, 20, 1'b0, 32'h0);
        idle(2, 1'b0);
        xfer(32'h00AF10FF, 20, 1'b0, 32'h0);
        idle(2, 1'b1);
        foreach (words[i]) words[i] = $urandom;
        for (int i = 0; i < 8; i++) begin
            bit keep;
            keep = 1'($urandom_range(0, 1));
            xfer(words[i], $urandom_range(1, 30), keep, words[i+1]);
            if (!keep) idle($urandom_range(1, 3), 1'b1);
        end
        idle(1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            bq_t qc;
            c_word = 8'($urandom);
            qc = model({24'd0, c_word}, 1'b1, 1);
            c_valid = 1'b1;
            foreach (qc[k]) begin
                @(negedge clk);
                c_valid = 1'b0;
                check("c_start", {31'd0, c_start}, 1);
                check("c_din", {24'd0, c_din}, {24'd0, qc[k]});
                repeat ($urandom_range(1, 10)) begin
                    @(negedge clk);
                    check("c_wait", {30'd0, c_start, c_done}, 0);
                end
                c_txdone = 1'b1;
                @(negedge clk);
                c_txdone = 1'b0;
            end
            check("c_done", {31'd0, c_done}, 1);
            check("c_ready", {31'd0, c_ready}, 1);
            @(negedge clk);
            check("c_done_pulse", {31'd0, c_done}, 0);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
